// File: rtl/axis_out_downsizer.sv
// AXI-Stream downsizer: holds one wide input beat and emits its non-empty
// M_WORDS-wide chunks in ascending order. Drop beats (user[0]=1) and empty
// non-last beats are swallowed; an empty last beat yields a single empty
// last output beat so packet boundaries are preserved downstream.
module axis_out_downsizer #(
    parameter int WORD_WIDTH = 32,
    parameter int S_WORDS    = 16,
    parameter int M_WORDS    = 4,
    parameter int USER_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tvalid,
    input  logic [S_WORDS*WORD_WIDTH-1:0] s_axis_tdata,
    input  logic [S_WORDS-1:0]            s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [M_WORDS*WORD_WIDTH-1:0] m_axis_tdata,
    output logic [M_WORDS-1:0]            m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser
);

    localparam int R       = S_WORDS / M_WORDS;
    localparam int IDX_W   = (R > 1) ? $clog2(R) : 1;
    localparam int CHUNK_W = M_WORDS * WORD_WIDTH;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;

    // Holding register and control state
    logic [S_WORDS*WORD_WIDTH-1:0] data_q, data_d;
    logic [S_WORDS-1:0]            keep_q, keep_d;
    logic                          last_q, last_d;
    logic [USER_WIDTH-1:0]         user_q, user_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [0:0]                    state_q, state_d;

    // Derived control signals
    logic [R-1:0]     held_nz_s;
    logic [R-1:0]     in_nz_s;
    logic             has_next_s;
    logic [IDX_W-1:0] next_idx_s;
    logic [IDX_W-1:0] in_first_s;
    logic             is_final_s;
    logic             send_s;
    logic             out_hs_s;
    logic             done_s;
    logic             accept_s;
    logic             load_s;

    // Per-chunk "has at least one kept word" flags for the held and incoming beats
    always_comb begin
        held_nz_s = '0;
        in_nz_s   = '0;
        for (int k = 0; k < R; k++) begin
            held_nz_s[k] = |keep_q[k*M_WORDS +: M_WORDS];
            in_nz_s[k]   = |s_axis_tkeep[k*M_WORDS +: M_WORDS];
        end
    end

    // Find the next non-empty held chunk above idx, and the first non-empty incoming chunk
    always_comb begin
        has_next_s = 1'b0;
        next_idx_s = '0;
        in_first_s = '0;
        // Scanning downward leaves the lowest qualifying index in each result
        for (int k = R - 1; k >= 0; k--) begin
            has_next_s = (held_nz_s[k] && (k > int'(idx_q))) ? 1'b1 : has_next_s;
            next_idx_s = (held_nz_s[k] && (k > int'(idx_q))) ? IDX_W'(k) : next_idx_s;
            in_first_s = in_nz_s[k] ? IDX_W'(k) : in_first_s;
        end
    end

    // Handshake decode; the input side opens in the same cycle the last chunk leaves
    always_comb begin
        is_final_s    = ~has_next_s;
        send_s        = (state_q == ST_SEND);
        out_hs_s      = send_s & m_axis_tready;
        done_s        = out_hs_s & is_final_s;
        s_axis_tready = ~rst & (~send_s | done_s);
        accept_s      = s_axis_tvalid & s_axis_tready;
        load_s        = accept_s & ~s_axis_tuser[0] & ((|s_axis_tkeep) | s_axis_tlast);
    end

    // Next-state: reload on a producing accept, retire on final chunk, else step idx
    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        idx_d   = idx_q;
        state_d = state_q;
        if (load_s) begin
            // An empty last beat must present zero data on its single output beat
            data_d  = (|s_axis_tkeep) ? s_axis_tdata : '0;
            keep_d  = s_axis_tkeep;
            last_d  = s_axis_tlast;
            user_d  = s_axis_tuser;
            idx_d   = in_first_s;
            state_d = ST_SEND;
        end else if (done_s) begin
            idx_d   = '0;
            state_d = ST_EMPTY;
        end else if (out_hs_s) begin
            idx_d   = next_idx_s;
            state_d = state_q;
        end else begin
            idx_d   = idx_q;
            state_d = state_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_EMPTY;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Output chunk mux from the holding register; outputs read zero when idle
    always_comb begin
        m_axis_tvalid = send_s;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        if (send_s) begin
            m_axis_tdata = data_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
            m_axis_tkeep = keep_q[int'(idx_q)*M_WORDS +: M_WORDS];
            m_axis_tlast = last_q & is_final_s;
            m_axis_tuser = user_q;
        end else begin
            m_axis_tdata = '0;
            m_axis_tkeep = '0;
            m_axis_tlast = 1'b0;
            m_axis_tuser = '0;
        end
    end

endmodule

// File: tb/tb_axis_out_downsizer.sv
// Testbench for axis_out_downsizer (32-bit words, 8 in, 2 out, R=4).
// A queue-based reference model expands each accepted beat into the expected
// output chunks; directed scenarios plus a randomized soak are checked against it.
module tb_axis_out_downsizer;

    localparam int WW = 32;
    localparam int SW = 8;
    localparam int MW = 2;
    localparam int UW = 2;
    localparam int R  = SW / MW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_axis_tready;
    logic              s_axis_tvalid = 1'b0;
    logic [SW*WW-1:0]  s_axis_tdata  = '0;
    logic [SW-1:0]     s_axis_tkeep  = '0;
    logic              s_axis_tlast  = 1'b0;
    logic [UW-1:0]     s_axis_tuser  = '0;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tvalid;
    logic [MW*WW-1:0]  m_axis_tdata;
    logic [MW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [UW-1:0]     m_axis_tuser;

    axis_out_downsizer #(
        .WORD_WIDTH(WW), .S_WORDS(SW), .M_WORDS(MW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  keep;
        logic        last;
        logic [1:0]  user;
        logic        fin;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t out_log[$];
    int    acc_log[$];
    int    cyc = 0;
    int    tests_run = 0;
    int    tests_failed = 0;
    int    rdy_mode = 0;
    int    rdy_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: expand an accepted input beat into expected output chunks
    task automatic model_push(input logic [SW*WW-1:0] d, input logic [SW-1:0] k,
                              input logic l, input logic [UW-1:0] u);
        beat_t b;
        int top;
        if (u[0]) return;
        if (k == '0) begin
            if (l) begin
                b.data = '0; b.keep = '0; b.last = 1'b1; b.user = u; b.fin = 1'b1; b.cyc = 0;
                exp_q.push_back(b);
            end
            return;
        end
        top = 0;
        for (int c = 0; c < R; c++) if (k[c*MW +: MW] != '0) top = c;
        for (int c = 0; c < R; c++) begin
            if (k[c*MW +: MW] != '0) begin
                b.data = d[c*MW*WW +: MW*WW];
                b.keep = k[c*MW +: MW];
                b.fin  = (c == top);
                b.last = l && (c == top);
                b.user = u;
                b.cyc  = 0;
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic logic [SW*WW-1:0] full_data(input logic [31:0] base);
        logic [SW*WW-1:0] d;
        for (int i = 0; i < SW; i++) d[i*WW +: WW] = base + 32'(i);
        return d;
    endfunction

    function automatic logic [63:0] pair(input logic [31:0] base, input int j);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = base + 32'(2*j);
        hi = base + 32'(2*j + 1);
        return {hi, lo};
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // m_axis_tready generator: 0 = always, 1 = 1,0,0 pattern, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: begin m_axis_tready = (rdy_cnt % 3 == 0); rdy_cnt++; end
            2: m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b1;
        endcase
    end

    // Monitor: scoreboard outputs, stability under stall, ready behaviour, reset values
    initial begin
        logic        rst_prev;
        logic        stall_prev;
        logic [63:0] st_data;
        logic [1:0]  st_keep;
        logic        st_last;
        logic [1:0]  st_user;
        beat_t       e;
        beat_t       o;
        rst_prev = 1'b0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rst_prev) begin
                    check_eq("rst_m_tvalid", m_axis_tvalid, 0);
                    check_eq("rst_s_tready", s_axis_tready, 0);
                    check_eq("rst_m_tdata", m_axis_tdata, 0);
                    check_eq("rst_m_tkeep", m_axis_tkeep, 0);
                    check_eq("rst_m_tlast", m_axis_tlast, 0);
                    check_eq("rst_m_tuser", m_axis_tuser, 0);
                end
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("stall_tvalid", m_axis_tvalid, 1);
                    check_eq("stall_tdata", m_axis_tdata, st_data);
                    check_eq("stall_tkeep", m_axis_tkeep, st_keep);
                    check_eq("stall_tlast", m_axis_tlast, st_last);
                    check_eq("stall_tuser", m_axis_tuser, st_user);
                end
                if (m_axis_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_beat", m_axis_tvalid, 0);
                    end else begin
                        e = exp_q[0];
                        check_eq("s_tready_busy", s_axis_tready, m_axis_tready & e.fin);
                        if (m_axis_tready) begin
                            check_eq("m_tdata", m_axis_tdata, e.data);
                            check_eq("m_tkeep", m_axis_tkeep, e.keep);
                            check_eq("m_tlast", m_axis_tlast, e.last);
                            check_eq("m_tuser", m_axis_tuser, e.user);
                            void'(exp_q.pop_front());
                            o.data = m_axis_tdata; o.keep = m_axis_tkeep; o.last = m_axis_tlast;
                            o.user = m_axis_tuser; o.fin = e.fin; o.cyc = cyc;
                            out_log.push_back(o);
                        end
                    end
                end else begin
                    check_eq("s_tready_idle", s_axis_tready, 1);
                    check_eq("idle_no_pending", exp_q.size(), 0);
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    model_push(s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser);
                    acc_log.push_back(cyc);
                end
                stall_prev = m_axis_tvalid & ~m_axis_tready;
                st_data = m_axis_tdata; st_keep = m_axis_tkeep;
                st_last = m_axis_tlast; st_user = m_axis_tuser;
            end
            rst_prev = rst;
        end
    end

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [SW*WW-1:0] d, input logic [SW-1:0] k,
                             input logic l, input logic [UW-1:0] u);
        bit hs;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
        s_axis_tvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin hs = 1'b1; break; end
        end
        if (!hs) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !m_axis_tvalid) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("drain_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        out_log.delete();
        acc_log.delete();
    endtask

    initial begin
        logic [SW*WW-1:0] d;
        logic [SW-1:0]    k;
        bit ok;

        // Reset and first cycle after it
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("tready_after_rst", s_axis_tready, 1);
        check_eq("tvalid_after_rst", m_axis_tvalid, 0);
        @(posedge clk); #1;

        // Full beat, ready held high
        rdy_mode = 0;
        clear_logs();
        send_beat(full_data(32'h10), 8'hFF, 1'b1, 2'b00);
        wait_drain();
        check_eq("full_count", out_log.size(), 4);
        if (out_log.size() == 4 && acc_log.size() == 1) begin
            for (int j = 0; j < 4; j++) begin
                check_eq("full_data", out_log[j].data, pair(32'h10, j));
                check_eq("full_keep", out_log[j].keep, 2'b11);
                check_eq("full_last", out_log[j].last, (j == 3));
            end
            check_eq("full_latency", out_log[0].cyc - acc_log[0], 1);
            check_eq("full_span", out_log[3].cyc - out_log[0].cyc, 3);
        end

        // Sparse keep: only chunks 0 and 3
        clear_logs();
        send_beat(full_data(32'h10), 8'b1100_0011, 1'b1, 2'b10);
        wait_drain();
        check_eq("sparse_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check_eq("sparse_c0", out_log[0].data, pair(32'h10, 0));
            check_eq("sparse_c3", out_log[1].data, pair(32'h10, 3));
            check_eq("sparse_last0", out_log[0].last, 0);
            check_eq("sparse_last3", out_log[1].last, 1);
            check_eq("sparse_user", out_log[1].user, 2'b10);
        end

        // Drop beat, empty non-last, empty last
        clear_logs();
        send_beat(full_data(32'h40), 8'hFF, 1'b1, 2'b01);
        send_beat(full_data(32'h50), 8'h00, 1'b0, 2'b00);
        send_beat(full_data(32'h60), 8'h00, 1'b1, 2'b10);
        wait_drain();
        check_eq("empty_count", out_log.size(), 1);
        if (out_log.size() == 1) begin
            check_eq("empty_data", out_log[0].data, 0);
            check_eq("empty_keep", out_log[0].keep, 0);
            check_eq("empty_last", out_log[0].last, 1);
            check_eq("empty_user", out_log[0].user, 2'b10);
        end

        // Backpressure 1,0,0,...
        rdy_cnt = 0;
        rdy_mode = 1;
        clear_logs();
        send_beat(full_data(32'h80), 8'hFF, 1'b0, 2'b00);
        wait_drain();
        check_eq("bp_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            for (int j = 0; j < 4; j++) check_eq("bp_data", out_log[j].data, pair(32'h80, j));
            check_eq("bp_last", out_log[3].last, 0);
        end
        rdy_mode = 0;
        idle(2);

        // Streaming: three full beats back to back
        clear_logs();
        send_beat(full_data(32'h100), 8'hFF, 1'b0, 2'b00);
        send_beat(full_data(32'h200), 8'hFF, 1'b0, 2'b00);
        send_beat(full_data(32'h300), 8'hFF, 1'b1, 2'b00);
        wait_drain();
        check_eq("stream_count", out_log.size(), 12);
        check_eq("stream_accepts", acc_log.size(), 3);
        if (out_log.size() == 12 && acc_log.size() == 3) begin
            check_eq("stream_span", out_log[11].cyc - out_log[0].cyc, 11);
            check_eq("stream_gap1", acc_log[1] - acc_log[0], 4);
            check_eq("stream_gap2", acc_log[2] - acc_log[1], 4);
            check_eq("stream_first_b2", out_log[4].data, pair(32'h200, 0));
            check_eq("stream_last", out_log[11].last, 1);
        end

        // Reset after two of four chunks
        clear_logs();
        send_beat(full_data(32'h500), 8'hFF, 1'b1, 2'b00);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_log.size() >= 2) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check_eq("midrst_timeout", 0, 1);
        check_eq("midrst_pending", m_axis_tvalid, 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_tvalid_after", m_axis_tvalid, 0);
        @(posedge clk); #1;
        clear_logs();
        send_beat(full_data(32'h600), 8'hFF, 1'b1, 2'b00);
        wait_drain();
        check_eq("midrst_count", out_log.size(), 4);
        if (out_log.size() >= 1) check_eq("midrst_chunk0", out_log[0].data, pair(32'h600, 0));

        // Randomized soak against the reference model
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) rdy_mode = $urandom_range(0, 2);
            for (int i = 0; i < SW; i++) d[i*WW +: WW] = $urandom;
            for (int c = 0; c < R; c++) k[c*MW +: MW] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) k = '0;
            send_beat(d, k, 1'($urandom_range(0, 1)),
                      {1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
